// File: rtl/instr_memory_port.sv
`default_nettype none
// ============================================================================
// Module   : instr_memory_port
// Purpose  : Instruction memory with a program-load write port, a registered
//            fetch port, a count of loaded locations, and a full-memory
//            readback (dump) stream for checking a loaded program.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            wr_instr_en/_addr/wr_instr - program-load write, one word/cycle
//            fetch_addr -> fetch_instr  - 1-cycle registered fetch
//            load_count           - distinct locations written since reset
//            dump_start           - request readback (accepted in IDLE only)
//            dump_busy/_valid/_addr/_data/_done - readback stream
// Revision : 1.0 - initial release
// ============================================================================
module instr_memory_port #(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h000007C0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_instr_en,
    input  logic [ADDR_W-1:0] wr_instr_addr,
    input  logic [DATA_W-1:0] wr_instr,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic [ADDR_W:0]   load_count,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam int              c_depth     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_count_one = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_addr_last = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [c_depth-1:0] r_valid;
    logic [ADDR_W:0]   r_load_count;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_count;
    logic              w_read_en;

    // First dump stage: the word read at the edge the counter addresses it.
    logic              r_s1_valid;
    logic              r_s1_last;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [DATA_W-1:0] r_s1_data;

    logic [DATA_W-1:0] w_fetch_word;
    logic [DATA_W-1:0] w_dump_word;

    // Write-first read: a same-edge write to the addressed location wins,
    // otherwise unloaded locations read as NOP.
    assign w_fetch_word = (wr_instr_en && (wr_instr_addr == fetch_addr)) ? wr_instr :
                          (r_valid[fetch_addr] ? r_mem[fetch_addr] : NOP_WORD);
    assign w_dump_word  = (wr_instr_en && (wr_instr_addr == r_count)) ? wr_instr :
                          (r_valid[r_count] ? r_mem[r_count] : NOP_WORD);

    // Array contents are deliberately not reset; the valid bits mask them.
    always_ff @(posedge clk) begin
        if (wr_instr_en && !rst) begin
            r_mem[wr_instr_addr] <= wr_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_load_count <= '0;
        end else if (wr_instr_en) begin
            r_valid[wr_instr_addr] <= 1'b1;
            if (!r_valid[wr_instr_addr]) begin
                r_load_count <= r_load_count + c_count_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_instr <= '0;
        end else begin
            fetch_instr <= w_fetch_word;
        end
    end

    // Dump FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && dump_start) begin
                r_count <= '0;
            end else if (r_state == S_RUN) begin
                r_count <= r_count + c_addr_one;  // wraps to 0 after last address
            end
        end
    end

    // Dump FSM: next state and read enable
    always_comb begin
        w_state_next = r_state;
        w_read_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dump_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_read_en = 1'b1;
                if (r_count == c_addr_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_read_en;
            if (w_read_en) begin
                r_s1_last <= (r_count == c_addr_last);
                r_s1_addr <= r_count;
                r_s1_data <= w_dump_word;
            end
        end
    end

    // Output stage: address/data hold their last beat while not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            dump_valid <= r_s1_valid;
            dump_done  <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                dump_addr <= r_s1_addr;
                dump_data <= r_s1_data;
            end
        end
    end

    assign dump_busy  = r_s1_valid;
    assign load_count = r_load_count;

endmodule
`default_nettype wire
